// File: rtl/cache_if_pkg.sv
// Shared types for the cache port protocol between the cache arbiter and the
// banked data RAM.
//   CacheIF    : one per-bank, per-port request (ce/we active low, byte mask).
//   RamState_t : RAM controller states (post-reset clear sweep, normal run).
//   row_of()   : strips the bank-select field out of an address to form the
//                row index inside a bank.
package cache_if_pkg;

  localparam int C_NUM_BANKS   = 4;
  localparam int C_BANK_OFFSET = 0;
  localparam int C_ADDR_BITS   = 12;
  localparam int C_DATA_WIDTH  = 32;

  typedef struct packed {
    logic                        ce;
    logic                        we;
    logic [C_ADDR_BITS-1:0]      addr;
    logic [C_DATA_WIDTH-1:0]     data;
    logic [C_DATA_WIDTH/8-1:0]   wmask;
  } CacheIF;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } RamState_t;

  // Returns {addr above the bank field, addr below the bank field}, right
  // aligned; the caller truncates to its row width.
  function automatic logic [C_ADDR_BITS-1:0] row_of(
    input logic [C_ADDR_BITS-1:0] addr,
    input int                     bank_offset,
    input int                     bank_bits
  );
    logic [C_ADDR_BITS-1:0] lo_mask;
    logic [C_ADDR_BITS-1:0] upper;
    lo_mask = (C_ADDR_BITS'(1'b1) << bank_offset) - C_ADDR_BITS'(1'b1);
    upper   = addr >> (bank_offset + bank_bits);
    return (upper << bank_offset) | (addr & lo_mask);
  endfunction

endpackage

// File: rtl/banked_cache_ram_bank.sv
// One bank of the cache data RAM.
//   clk, rst : clock and synchronous active-low reset.
//   ports    : per-port requests for this bank (already routed by the arbiter).
//   req_en   : requests are honoured only while high (RUN and not in reset).
//   clr_en   : zero row clr_idx this cycle (clear sweep).
//   clr_idx  : row being cleared.
//   rdata    : per-port read data, two register stages after the array read.
//   conflict : combinational; two or more writes target the same row now.
module banked_cache_ram_bank
  import cache_if_pkg::*;
#(
  parameter int NUM_PORTS   = 3,
  parameter int NUM_R       = 1,
  parameter int NUM_W       = 1,
  parameter int NUM_RW      = 1,
  parameter int BANK_OFFSET = 0,
  parameter int BANK_BITS   = 2,
  parameter int ROW_BITS    = 10,
  parameter int DATA_WIDTH  = 32,
  parameter type IF_t       = CacheIF
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  IF_t   [NUM_PORTS-1:0]                ports,
  input  logic                                 req_en,
  input  logic                                 clr_en,
  input  logic  [ROW_BITS-1:0]                 clr_idx,
  output logic  [NUM_PORTS-1:0][DATA_WIDTH-1:0] rdata,
  output logic                                 conflict
);

  localparam int DEPTH     = 1 << ROW_BITS;
  localparam int NUM_BYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0]                 mem_r [DEPTH];
  logic [ROW_BITS-1:0]                   row_s [NUM_PORTS];
  logic [NUM_PORTS-1:0]                  wr_s;
  logic [NUM_PORTS-1:0]                  rd_s;
  logic [NUM_PORTS-1:0]                  s1_valid_r;
  logic [DATA_WIDTH-1:0]                 s1_data_r [NUM_PORTS];
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  rdata_r;
  logic                                  conflict_s;

  // Per-port access decode: row index and read/write intent by port type.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      row_s[p] = ROW_BITS'(row_of(ports[p].addr, BANK_OFFSET, BANK_BITS));
      wr_s[p]  = 1'b0;
      rd_s[p]  = 1'b0;
      if (req_en && !ports[p].ce) begin
        if (p < NUM_R) begin
          rd_s[p] = 1'b1;                 // read-only: we is ignored
        end else if (p < NUM_R + NUM_W) begin
          wr_s[p] = 1'b1;                 // write-only: any enabled access writes
        end else if (NUM_RW != 0) begin
          rd_s[p] = ports[p].we;
          wr_s[p] = !ports[p].we;
        end else begin
          wr_s[p] = 1'b0;
        end
      end else begin
        wr_s[p] = 1'b0;
        rd_s[p] = 1'b0;
      end
    end
  end

  // Same-row write collision detect across every port pair of this bank.
  always_comb begin
    conflict_s = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      for (int j = i + 1; j < NUM_PORTS; j++) begin
        conflict_s = conflict_s | (wr_s[i] & wr_s[j] & (row_s[i] == row_s[j]));
      end
    end
  end

  // Array update: clear sweep, else byte-masked writes. Ports are visited in
  // ascending order so the last non-blocking write (highest port) wins a byte.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem_r[clr_idx] <= {DATA_WIDTH{1'b0}};
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        for (int b = 0; b < NUM_BYTES; b++) begin
          if (wr_s[p] && ports[p].wmask[b]) begin
            mem_r[row_s[p]][b*8 +: 8] <= ports[p].data[b*8 +: 8];
          end
        end
      end
    end
  end

  // Two-stage read pipeline; the array read sees contents from before this
  // edge's writes. Stage 2 only loads for a valid stage 1 so it holds the last
  // read result while the port is idle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid_r <= {NUM_PORTS{1'b0}};
      for (int p = 0; p < NUM_PORTS; p++) begin
        s1_data_r[p] <= {DATA_WIDTH{1'b0}};
        rdata_r[p]   <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        s1_valid_r[p] <= rd_s[p];
        if (rd_s[p]) begin
          s1_data_r[p] <= mem_r[row_s[p]];
        end
        if (s1_valid_r[p]) begin
          rdata_r[p] <= s1_data_r[p];
        end
      end
    end
  end

  assign rdata    = rdata_r;
  assign conflict = conflict_s;

endmodule

// File: rtl/banked_cache_ram.sv
// Multi-bank, multi-port cache data RAM (responder side of the cache port).
//   clk           : clock, rising edge.
//   rst           : synchronous active-low reset; restarts the clear sweep.
//   IN_ports      : [bank][port] requests as laid out by the arbiter.
//   OUT_portRData : [bank][port] read data, two cycles after the read is taken.
//   OUT_busy      : high while the post-reset clear sweep runs; requests ignored.
//   OUT_conflict  : registered; one-cycle pulse after a same-row write collision.
module banked_cache_ram
  import cache_if_pkg::*;
#(
  parameter int NUM_BANKS   = C_NUM_BANKS,
  parameter int NUM_PORTS   = 3,
  parameter int NUM_R       = 1,
  parameter int NUM_RW      = 1,
  parameter int NUM_W       = NUM_PORTS - NUM_R - NUM_RW,
  parameter int BANK_OFFSET = C_BANK_OFFSET,
  parameter int ADDR_BITS   = C_ADDR_BITS,
  parameter int DATA_WIDTH  = C_DATA_WIDTH,
  parameter type IF_t       = CacheIF
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  IF_t  [NUM_BANKS-1:0][NUM_PORTS-1:0]                  IN_ports,
  output logic [NUM_BANKS-1:0][NUM_PORTS-1:0][DATA_WIDTH-1:0]  OUT_portRData,
  output logic                                                 OUT_busy,
  output logic                                                 OUT_conflict
);

  localparam int BANK_BITS = $clog2(NUM_BANKS);
  localparam int ROW_BITS  = ADDR_BITS - BANK_BITS;
  localparam int DEPTH     = 1 << ROW_BITS;

  RamState_t            state_r;
  RamState_t            state_next_s;
  logic [ROW_BITS-1:0]  clr_idx_r;
  logic [ROW_BITS-1:0]  clr_idx_next_s;
  logic                 busy_r;
  logic                 conflict_r;
  logic                 clr_en_s;
  logic                 req_en_s;
  logic [NUM_BANKS-1:0] bank_conflict_s;

  // Reset wins over both the sweep and requests in the cycle it is asserted.
  assign clr_en_s = rst & (state_r == CLEAR);
  assign req_en_s = rst & (state_r == RUN);

  // Next-state logic: sweep every row once, then stay in RUN until reset.
  // The index holds at the last row instead of wrapping.
  always_comb begin
    state_next_s   = state_r;
    clr_idx_next_s = clr_idx_r;
    case (state_r)
      CLEAR: begin
        if (clr_idx_r == ROW_BITS'(DEPTH - 1)) begin
          state_next_s = RUN;
        end else begin
          clr_idx_next_s = clr_idx_r + ROW_BITS'(1'b1);
        end
      end
      RUN: begin
        state_next_s = RUN;
      end
      default: begin
        state_next_s   = CLEAR;
        clr_idx_next_s = {ROW_BITS{1'b0}};
      end
    endcase
  end

  // State, sweep index and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= CLEAR;
      clr_idx_r  <= {ROW_BITS{1'b0}};
      busy_r     <= 1'b1;
      conflict_r <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      clr_idx_r  <= clr_idx_next_s;
      busy_r     <= (state_next_s == CLEAR);
      conflict_r <= |bank_conflict_s;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    banked_cache_ram_bank #(
      .NUM_PORTS   (NUM_PORTS),
      .NUM_R       (NUM_R),
      .NUM_W       (NUM_W),
      .NUM_RW      (NUM_RW),
      .BANK_OFFSET (BANK_OFFSET),
      .BANK_BITS   (BANK_BITS),
      .ROW_BITS    (ROW_BITS),
      .DATA_WIDTH  (DATA_WIDTH),
      .IF_t        (IF_t)
    ) u_bank (
      .clk      (clk),
      .rst      (rst),
      .ports    (IN_ports[b]),
      .req_en   (req_en_s),
      .clr_en   (clr_en_s),
      .clr_idx  (clr_idx_r),
      .rdata    (OUT_portRData[b]),
      .conflict (bank_conflict_s[b])
    );
  end

  assign OUT_busy     = busy_r;
  assign OUT_conflict = conflict_r;

endmodule

// File: tb/tb_banked_cache_ram.sv
// Scoreboard bench for banked_cache_ram: stimulus pushes expected values tagged
// with the cycle they are due; a negedge monitor pops and compares them.
module tb_banked_cache_ram;
  import cache_if_pkg::*;

  logic                   clk;
  logic                   rst;
  CacheIF [3:0][2:0]      req;
  logic [3:0][2:0][31:0]  rdata;
  logic                   busy;
  logic                   conflict;

  banked_cache_ram dut (
    .clk           (clk),
    .rst           (rst),
    .IN_ports      (req),
    .OUT_portRData (rdata),
    .OUT_busy      (busy),
    .OUT_conflict  (conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 = read data of [b][p], 1 = busy, 2 = conflict
  typedef struct {
    int          due;
    int          kind;
    int          b;
    int          p;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push(input string name, input int off, input int kind,
                      input int b, input int p, input logic [31:0] val);
    exp_t e;
    e.due  = cyc + off;
    e.kind = kind;
    e.b    = b;
    e.p    = p;
    e.val  = val;
    e.name = name;
    sb.push_back(e);
  endtask

  // Monitor: compare every expectation due at this cycle.
  always @(negedge clk) begin : mon
    int          i;
    logic [31:0] act;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].due == cyc) begin
        case (sb[i].kind)
          0:       act = rdata[sb[i].b][sb[i].p];
          1:       act = {31'd0, busy};
          default: act = {31'd0, conflict};
        endcase
        chk(sb[i].name, act, sb[i].val);
        sb.delete(i);
      end else if (sb[i].due < cyc) begin
        n_vec++;
        n_miss++;
        $display("FAIL %s: not checked at cycle %0d, required cycle %0d", sb[i].name, cyc, sb[i].due);
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  function automatic logic [11:0] mk_addr(input int b, input int r);
    return 12'((r << 2) | b);
  endfunction

  task automatic idle_all();
    for (int b = 0; b < 4; b++) begin
      for (int p = 0; p < 3; p++) begin
        req[b][p].ce    = 1'b1;
        req[b][p].we    = 1'b1;
        req[b][p].addr  = 12'd0;
        req[b][p].data  = 32'd0;
        req[b][p].wmask = 4'd0;
      end
    end
  endtask

  task automatic set_req(input int b, input int p, input logic we, input int row,
                         input logic [31:0] data, input logic [3:0] mask);
    req[b][p].ce    = 1'b0;
    req[b][p].we    = we;
    req[b][p].addr  = mk_addr(b, row);
    req[b][p].data  = data;
    req[b][p].wmask = mask;
  endtask

  // Let the edge sample the current requests, then go idle.
  task automatic step();
    @(negedge clk);
    idle_all();
  endtask

  initial begin : stim
    int cnt;
    int guard;
    rst = 1'b0;
    idle_all();
    repeat (3) @(negedge clk);

    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_conflict", {31'd0, conflict}, 32'd0);
    for (int b = 0; b < 4; b++) begin
      for (int p = 0; p < 3; p++) begin
        chk($sformatf("rst_rdata_b%0dp%0d", b, p), rdata[b][p], 32'd0);
      end
    end

    // Clear sweep must last exactly DEPTH = 1024 cycles.
    rst = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (busy && cnt < 2000);
    chk("clear_cycles", cnt, 32'd1024);
    chk("busy_in_run", {31'd0, busy}, 32'd0);

    set_req(2, 0, 1'b1, 5, 32'd0, 4'd0);
    push("cleared_b2r5", 2, 0, 2, 0, 32'h0000_0000);
    step();

    // Write-only port writes even with we=1.
    set_req(1, 1, 1'b1, 3, 32'hDEAD_BEEF, 4'hF);
    push("single_write_no_conflict", 1, 2, 0, 0, 32'd0);
    step();

    set_req(1, 0, 1'b1, 3, 32'd0, 4'd0);
    push("latency_not_one", 1, 0, 1, 0, 32'h0000_0000);
    push("latency_two", 2, 0, 1, 0, 32'hDEAD_BEEF);
    step();

    set_req(1, 2, 1'b0, 7, 32'h1122_3344, 4'hF);
    step();
    set_req(1, 1, 1'b1, 7, 32'hAABB_CCDD, 4'b0101);
    step();
    set_req(1, 1, 1'b1, 7, 32'hFFFF_FFFF, 4'b0000);   // no-op write
    step();

    // Read-only port with we=0 still reads; RW port with we=1 reads.
    set_req(1, 0, 1'b0, 7, 32'd0, 4'd0);
    set_req(1, 2, 1'b1, 7, 32'd0, 4'd0);
    push("bytemask_p0", 2, 0, 1, 0, 32'h11BB_33DD);
    push("bytemask_p2", 2, 0, 1, 2, 32'h11BB_33DD);
    push("wonly_rdata_zero", 2, 0, 1, 1, 32'h0000_0000);
    step();

    set_req(0, 0, 1'b1, 9, 32'd0, 4'd0);
    set_req(0, 2, 1'b0, 9, 32'h0000_0055, 4'hF);
    push("read_first_old", 2, 0, 0, 0, 32'h0000_0000);
    step();
    set_req(0, 0, 1'b1, 9, 32'd0, 4'd0);
    push("read_after_write", 2, 0, 0, 0, 32'h0000_0055);
    step();

    set_req(3, 1, 1'b1, 4, 32'h0000_00AA, 4'b0001);
    set_req(3, 2, 1'b0, 4, 32'h0000_00BB, 4'b0011);
    push("conflict_pulse", 1, 2, 0, 0, 32'd1);
    push("conflict_one_cycle", 2, 2, 0, 0, 32'd0);
    step();
    set_req(3, 0, 1'b1, 4, 32'd0, 4'd0);
    push("high_port_wins", 2, 0, 3, 0, 32'h0000_00BB);
    step();

    // Writes to different rows, or same row in different banks: no conflict.
    set_req(2, 1, 1'b1, 1, 32'h0000_0001, 4'hF);
    set_req(2, 2, 1'b0, 2, 32'h0000_0002, 4'hF);
    set_req(0, 1, 1'b1, 1, 32'h0000_0003, 4'hF);
    set_req(1, 1, 1'b1, 1, 32'h0000_0004, 4'hF);
    push("diff_row_no_conflict", 1, 2, 0, 0, 32'd0);
    push("idle_hold_b0p0", 3, 0, 0, 0, 32'h0000_0055);
    push("idle_hold_b1p0", 3, 0, 1, 0, 32'h11BB_33DD);
    step();
    step();
    step();

    // Read in flight, then reset one edge later: the read must be dropped.
    set_req(1, 0, 1'b1, 3, 32'd0, 4'd0);
    push("rst_drops_read", 2, 0, 1, 0, 32'h0000_0000);
    push("rst_busy_again", 2, 1, 0, 0, 32'd1);
    push("stale_never_1", 3, 0, 1, 0, 32'h0000_0000);
    push("stale_never_2", 4, 0, 1, 0, 32'h0000_0000);
    step();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (busy && cnt < 2000);
    chk("reclear_cycles", cnt, 32'd1024);

    set_req(1, 0, 1'b1, 3, 32'd0, 4'd0);
    set_req(3, 0, 1'b1, 4, 32'd0, 4'd0);
    push("reclear_b1r3", 2, 0, 1, 0, 32'h0000_0000);
    push("reclear_b3r4", 2, 0, 3, 0, 32'h0000_0000);
    step();

    guard = 0;
    while (sb.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
